// File: rtl/icache_control_pkg.sv
// rtl/icache_control_pkg.sv - shared cache control types: FSM states and data-array write source encodings
package cache_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    WRITEBACK = 2'b01,
    ALLOCATE  = 2'b10,
    REFILL    = 2'b11
  } state_e;

  typedef logic [1:0] writing_t;

  localparam writing_t WR_PMEM = 2'b00;  // data array loads the line returned by pmem
  localparam writing_t WR_CPU  = 2'b01;  // data array takes the CPU masked write
  localparam writing_t WR_NONE = 2'b10;  // data array untouched

endpackage

// File: rtl/icache_control_if.sv
// rtl/icache_control_if.sv - CPU, physical-memory and datapath control signals between cache controller and datapath
// Ports (signals):
//   CPU side:   mem_read, mem_write (requests), mem_resp (completion pulse)
//   pmem side:  pmem_read, pmem_write (line requests), pmem_resp (transaction done)
//   datapath:   hit, dirty_out (status); tag_load, valid_load, dirty_load, dirty_in, writing (controls)
// Modports: master = cache controller, slave = datapath/CPU/pmem environment.
interface icache_control_if;
  import cache_pkg::*;

  logic     mem_read;
  logic     mem_write;
  logic     mem_resp;
  logic     hit;
  logic     dirty_out;
  logic     pmem_read;
  logic     pmem_write;
  logic     pmem_resp;
  logic     tag_load;
  logic     valid_load;
  logic     dirty_load;
  logic     dirty_in;
  writing_t writing;

  modport master (
    input  mem_read, mem_write, hit, dirty_out, pmem_resp,
    output mem_resp, pmem_read, pmem_write, tag_load, valid_load, dirty_load, dirty_in, writing
  );

  modport slave (
    output mem_read, mem_write, hit, dirty_out, pmem_resp,
    input  mem_resp, pmem_read, pmem_write, tag_load, valid_load, dirty_load, dirty_in, writing
  );

endinterface

// File: rtl/icache_control_sat_counter.sv
// rtl/icache_control_sat_counter.sv - saturating up-counter used for the cache performance counters
// Ports:
//   clk   in   clock
//   rst   in   asynchronous reset, active-low
//   inc   in   increment request for this cycle
//   count out  current value, sticks at all-ones
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/icache_control.sv
// rtl/icache_control.sv - cache control FSM: 0-cycle hits, dirty writeback then allocate on miss, perf counters
// Ports:
//   clk         in   clock
//   rst         in   asynchronous reset, active-low
//   bus         master modport of icache_control_if (CPU, pmem and datapath controls)
//   hit_count   out  requests completed as first-look hits (saturating)
//   miss_count  out  requests that entered miss handling (saturating)
//   wb_count    out  completed writebacks (saturating)
module icache_control
  import cache_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  icache_control_if.master  bus,
  output logic [CNT_W-1:0]  hit_count,
  output logic [CNT_W-1:0]  miss_count,
  output logic [CNT_W-1:0]  wb_count
);

  state_e state;
  logic   recheck;   // IDLE cycle directly after REFILL: its hit is not a first-look hit
  logic   req;
  logic   is_write;
  logic   hit_inc;
  logic   miss_inc;
  logic   wb_inc;

  assign req      = bus.mem_read | bus.mem_write;
  assign is_write = bus.mem_write;  // read+write together behaves as a write

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      recheck <= 1'b0;
    end else begin
      recheck <= 1'b0;
      case (state)
        IDLE: begin
          if (req && !bus.hit) begin
            state <= bus.dirty_out ? WRITEBACK : ALLOCATE;
          end
        end
        WRITEBACK: begin
          if (bus.pmem_resp) begin
            state <= ALLOCATE;
          end
        end
        ALLOCATE: begin
          if (bus.pmem_resp) begin
            state <= REFILL;
          end
        end
        REFILL: begin
          state   <= IDLE;
          recheck <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Mealy outputs; forced to defaults while reset is asserted so an
  // in-flight pmem request drops immediately.
  always_comb begin
    bus.mem_resp   = 1'b0;
    bus.pmem_read  = 1'b0;
    bus.pmem_write = 1'b0;
    bus.tag_load   = 1'b0;
    bus.valid_load = 1'b0;
    bus.dirty_load = 1'b0;
    bus.dirty_in   = 1'b0;
    bus.writing    = WR_NONE;
    hit_inc        = 1'b0;
    miss_inc       = 1'b0;
    wb_inc         = 1'b0;
    if (rst) begin
      case (state)
        IDLE: begin
          if (req) begin
            if (bus.hit) begin
              bus.mem_resp = 1'b1;
              hit_inc      = !recheck;
              if (is_write) begin
                bus.writing    = WR_CPU;
                bus.dirty_load = 1'b1;
                bus.dirty_in   = 1'b1;
              end
            end else begin
              miss_inc = 1'b1;
            end
          end
        end
        WRITEBACK: begin
          bus.pmem_write = 1'b1;
          if (bus.pmem_resp) begin
            // clearing dirty flips the datapath pmem address mux back to the CPU address
            bus.dirty_load = 1'b1;
            wb_inc         = 1'b1;
          end
        end
        ALLOCATE: begin
          bus.pmem_read = 1'b1;
          if (bus.pmem_resp) begin
            bus.writing    = WR_PMEM;
            bus.tag_load   = 1'b1;
            bus.valid_load = 1'b1;
            bus.dirty_load = 1'b1;
          end
        end
        REFILL: begin
          // bubble so the arrays present the new line before IDLE re-checks
        end
        default: begin
        end
      endcase
    end
  end

  sat_counter #(.W(CNT_W)) u_hit_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (hit_inc),
    .count (hit_count)
  );

  sat_counter #(.W(CNT_W)) u_miss_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (miss_inc),
    .count (miss_count)
  );

  sat_counter #(.W(CNT_W)) u_wb_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (wb_inc),
    .count (wb_count)
  );

endmodule

// File: tb/tb_icache_control.sv
// tb/tb_icache_control.sv - self-checking bench for icache_control against a transaction-level reference
module tb_icache_control;

  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic clk;
  logic rst;
  logic [CNT_W-1:0] hit_count;
  logic [CNT_W-1:0] miss_count;
  logic [CNT_W-1:0] wb_count;

  icache_control_if bus();

  icache_control #(.CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .hit_count  (hit_count),
    .miss_count (miss_count),
    .wb_count   (wb_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int failures;
  int m_hit;
  int m_miss;
  int m_wb;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] sat(input int v);
    return (v > CMAX) ? CMAX : v;
  endfunction

  // {mem_resp, pmem_read, pmem_write, tag_load, valid_load, dirty_load, dirty_in, writing}
  function automatic logic [8:0] ev(input logic resp, input logic pr, input logic pw, input logic tl,
                                    input logic vl, input logic dl, input logic din, input logic [1:0] wr);
    return {resp, pr, pw, tl, vl, dl, din, wr};
  endfunction

  function automatic logic [8:0] obs();
    return {bus.mem_resp, bus.pmem_read, bus.pmem_write, bus.tag_load, bus.valid_load,
            bus.dirty_load, bus.dirty_in, bus.writing};
  endfunction

  task automatic check_counters(input string tag);
    check({tag, "_hit_count"},  32'(hit_count),  sat(m_hit));
    check({tag, "_miss_count"}, 32'(miss_count), sat(m_miss));
    check({tag, "_wb_count"},   32'(wb_count),   sat(m_wb));
  endtask

  // Idle cycle: no request, random noise on hit/dirty/pmem_resp must not do anything.
  task automatic idle_cycle();
    @(negedge clk);
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
    bus.hit       = 1'($urandom);
    bus.dirty_out = 1'($urandom);
    bus.pmem_resp = 1'($urandom);
    #1;
    check("idle_outputs", 32'(obs()), 32'(ev(0, 0, 0, 0, 0, 0, 0, 2'b10)));
    check_counters("idle");
  endtask

  // One CPU request seen from the outside: a hit completes at once; a miss
  // writes back (if dirty) for wb_lat cycles, allocates for al_lat cycles,
  // bubbles once, then the re-check completes as an uncounted hit.
  task automatic do_request(input logic rd, input logic wr, input logic first_hit,
                            input logic dirty, input int wb_lat, input int al_lat);
    logic [1:0] hit_wr;
    logic       is_wr;
    is_wr  = wr;
    hit_wr = is_wr ? 2'b01 : 2'b10;

    @(negedge clk);
    bus.mem_read  = rd;
    bus.mem_write = wr;
    bus.hit       = first_hit;
    bus.dirty_out = dirty;
    bus.pmem_resp = 1'b0;
    #1;
    if (first_hit) begin
      check("first_hit", 32'(obs()), 32'(ev(1, 0, 0, 0, 0, is_wr, is_wr, hit_wr)));
      m_hit++;
    end else begin
      check("first_miss", 32'(obs()), 32'(ev(0, 0, 0, 0, 0, 0, 0, 2'b10)));
      m_miss++;
      if (dirty) begin
        for (int i = 0; i < wb_lat; i++) begin
          @(negedge clk);
          bus.hit       = 1'($urandom);
          bus.pmem_resp = (i == wb_lat - 1);
          #1;
          if (i == wb_lat - 1)
            check("wb_resp", 32'(obs()), 32'(ev(0, 0, 1, 0, 0, 1, 0, 2'b10)));
          else
            check("wb_wait", 32'(obs()), 32'(ev(0, 0, 1, 0, 0, 0, 0, 2'b10)));
        end
        m_wb++;
      end
      for (int i = 0; i < al_lat; i++) begin
        @(negedge clk);
        bus.hit       = 1'($urandom);
        bus.pmem_resp = (i == al_lat - 1);
        #1;
        if (i == al_lat - 1)
          check("alloc_resp", 32'(obs()), 32'(ev(0, 1, 0, 1, 1, 1, 0, 2'b00)));
        else
          check("alloc_wait", 32'(obs()), 32'(ev(0, 1, 0, 0, 0, 0, 0, 2'b10)));
      end
      @(negedge clk);
      bus.hit       = 1'b1;
      bus.pmem_resp = 1'($urandom);
      #1;
      check("refill_bubble", 32'(obs()), 32'(ev(0, 0, 0, 0, 0, 0, 0, 2'b10)));
      @(negedge clk);
      bus.pmem_resp = 1'b0;
      #1;
      check("recheck_hit", 32'(obs()), 32'(ev(1, 0, 0, 0, 0, is_wr, is_wr, hit_wr)));
    end
    @(negedge clk);
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
    bus.hit       = 1'b0;
    bus.pmem_resp = 1'b0;
    #1;
    check_counters("after_req");
  endtask

  // Reset while the allocate read is outstanding.
  task automatic reset_mid_alloc();
    @(negedge clk);
    bus.mem_read  = 1'b1;
    bus.mem_write = 1'b0;
    bus.hit       = 1'b0;
    bus.dirty_out = 1'b0;
    bus.pmem_resp = 1'b0;
    m_miss++;
    @(negedge clk);
    #1;
    check("pre_reset_alloc", 32'(obs()), 32'(ev(0, 1, 0, 0, 0, 0, 0, 2'b10)));
    @(negedge clk);
    #1;
    rst = 1'b0;
    #1;
    m_hit = 0; m_miss = 0; m_wb = 0;
    check("reset_drop", 32'(obs()), 32'(ev(0, 0, 0, 0, 0, 0, 0, 2'b10)));
    check_counters("reset_mid");
    @(negedge clk);
    bus.pmem_resp = 1'b1;
    #1;
    check("reset_hold", 32'(obs()), 32'(ev(0, 0, 0, 0, 0, 0, 0, 2'b10)));
    @(negedge clk);
    rst           = 1'b1;
    bus.mem_read  = 1'b0;
    bus.pmem_resp = 1'b0;
    #1;
    check("post_reset", 32'(obs()), 32'(ev(0, 0, 0, 0, 0, 0, 0, 2'b10)));
  endtask

  initial begin
    int sel;
    checks = 0; failures = 0;
    m_hit = 0; m_miss = 0; m_wb = 0;
    rst           = 1'b0;
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
    bus.hit       = 1'b0;
    bus.dirty_out = 1'b0;
    bus.pmem_resp = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", 32'(obs()), 32'(ev(0, 0, 0, 0, 0, 0, 0, 2'b10)));
    check_counters("reset");
    @(negedge clk);
    rst = 1'b1;

    do_request(1, 0, 1, 0, 0, 0);   // read hit
    do_request(0, 1, 1, 1, 0, 0);   // write hit
    do_request(1, 0, 0, 0, 0, 5);   // clean read miss, pmem 5 cycles
    do_request(0, 1, 0, 1, 3, 4);   // dirty write miss
    do_request(1, 1, 0, 1, 1, 1);   // read+write together, shortest pmem latency
    idle_cycle();

    reset_mid_alloc();
    do_request(1, 0, 1, 0, 0, 0);   // state is IDLE after reset
    for (int i = 0; i < 16; i++) do_request(1, 0, 1, 0, 0, 0);  // 17 hits total: saturate

    for (int i = 0; i < 60; i++) begin
      sel = $urandom_range(0, 2);
      do_request(sel != 1, sel != 0, 1'($urandom), 1'($urandom),
                 $urandom_range(1, 6), $urandom_range(1, 6));
      if ($urandom_range(0, 3) == 0) idle_cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
